// File: rtl/mem_stage_pkg.sv
// rv32i_types: pipeline register structs, funct3/opcode/FSM enums and writeback mux
// encodings shared between mem_stage and writeback.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    f3_lb  = 3'b000,
    f3_lh  = 3'b001,
    f3_lw  = 3'b010,
    f3_lbu = 3'b100,
    f3_lhu = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    f3_sb = 3'b000,
    f3_sh = 3'b001,
    f3_sw = 3'b010
  } store_f3_t;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  typedef enum logic [3:0] {
    rf_alu_out,
    rf_br_en,
    rf_u_imm,
    rf_pc_plus4,
    rf_lb,
    rf_lbu,
    rf_lh,
    rf_lhu,
    rf_lw
  } regfilemux_sel_t;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [31:0]     inst;
    rv32i_opcode_t   opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [31:0]     alu_out;
    logic [31:0]     rs2_v;
    logic [31:0]     u_imm;
    logic            br_en;
    logic            regf_we;
    regfilemux_sel_t regfilemux_sel;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [31:0]     inst;
    rv32i_opcode_t   opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [31:0]     alu_out;
    logic [31:0]     u_imm;
    logic            br_en;
    logic            regf_we;
    regfilemux_sel_t regfilemux_sel;
    logic [31:0]     dmem_addr;
    logic [3:0]      dmem_rmask;
    logic [3:0]      dmem_wmask;
    logic [31:0]     dmem_wdata;
  } mem_wb_stage_reg_t;

  // Value a non-memory instruction will write back, for forwarding out of MEM.
  function automatic logic [31:0] fwd_value(input ex_mem_stage_reg_t e);
    return (e.regfilemux_sel == rf_br_en)    ? {31'b0, e.br_en} :
           (e.regfilemux_sel == rf_u_imm)    ? e.u_imm :
           (e.regfilemux_sel == rf_pc_plus4) ? e.pc + 32'd4 :
           (e.regfilemux_sel == rf_alu_out)  ? e.alu_out : 32'b0;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// mem_lsu_align: byte masks, lane-aligned store data and alignment check for a load/store.
// Alignment check only exists with MEM_MISALIGN_TRAP_EN; otherwise misaligned is 0.
module mem_lsu_align
  import rv32i_types::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rs2_v,
  input  logic        i_load,
  input  logic        i_store,
  output logic [3:0]  o_rmask,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  logic [3:0] w_mask;

  // Shifts stay 4 bits wide, so lanes pushed past byte 3 are dropped.
  assign w_mask  = i_size[1] ? 4'hF :
                   i_size[0] ? 4'(4'b0011 << {i_addr[1], 1'b0}) :
                               4'(4'b0001 << i_addr);
  assign o_rmask = i_load  ? w_mask : 4'b0;
  assign o_wmask = i_store ? w_mask : 4'b0;
  assign o_wdata = i_size[1] ? i_rs2_v :
                   i_size[0] ? {2{i_rs2_v[15:0]}} : {4{i_rs2_v[7:0]}};

`ifdef MEM_MISALIGN_TRAP_EN
  assign o_misaligned = i_size[1] ? |i_addr : (i_size[0] & i_addr[0]);
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: rv32i MEM stage -- dmem request generation, IDLE/WAIT freeze FSM, mem_wb register.
// MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and raises a sticky misalign_err.
module mem_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  ex_mem_stage_reg_t ex_mem,
  output mem_wb_stage_reg_t mem_wb,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_resp,
  output logic              freeze_stall,
  output logic [31:0]       mem_fwd_v,
  output logic              misalign_err
);

  mem_state_t        r_state, w_state_nxt;
  mem_wb_stage_reg_t r_mem_wb, w_mem_wb_nxt;
  logic              w_load, w_store, w_mem_op, w_misaligned, w_suppressed, w_issue;
  logic [3:0]        w_rmask, w_wmask;
  logic [31:0]       w_wdata;

  assign w_load       = ex_mem.valid & (ex_mem.opcode == op_load);
  assign w_store      = ex_mem.valid & (ex_mem.opcode == op_store);
  assign w_mem_op     = w_load | w_store;
  assign w_suppressed = w_mem_op & w_misaligned;
  assign w_issue      = w_mem_op & !freeze_stall & !w_suppressed;

  mem_lsu_align u_align (
    .i_size       (ex_mem.funct3[1:0]),
    .i_addr       (ex_mem.alu_out[1:0]),
    .i_rs2_v      (ex_mem.rs2_v),
    .i_load       (w_load),
    .i_store      (w_store),
    .o_rmask      (w_rmask),
    .o_wmask      (w_wmask),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  // Request outputs are a one-cycle pulse in the issue cycle only.
  assign freeze_stall = (r_state == WAIT) & !dmem_resp;
  assign dmem_addr    = w_issue ? {ex_mem.alu_out[31:2], 2'b00} : 32'b0;
  assign dmem_rmask   = w_issue ? w_rmask : 4'b0;
  assign dmem_wmask   = w_issue ? w_wmask : 4'b0;
  assign dmem_wdata   = (w_issue & w_store) ? w_wdata : 32'b0;
  assign mem_fwd_v    = (ex_mem.valid & !w_mem_op) ? fwd_value(ex_mem) : 32'b0;

  // A response in the same cycle as a new issue keeps us in WAIT.
  always_comb begin
    w_state_nxt = (w_issue | freeze_stall) ? WAIT : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_mem_wb_nxt                = '0;
    w_mem_wb_nxt.valid          = ex_mem.valid;
    w_mem_wb_nxt.pc             = ex_mem.pc;
    w_mem_wb_nxt.inst           = ex_mem.inst;
    w_mem_wb_nxt.opcode         = ex_mem.opcode;
    w_mem_wb_nxt.funct3         = ex_mem.funct3;
    w_mem_wb_nxt.rd             = ex_mem.rd;
    w_mem_wb_nxt.alu_out        = ex_mem.alu_out;
    w_mem_wb_nxt.u_imm          = ex_mem.u_imm;
    w_mem_wb_nxt.br_en          = ex_mem.br_en;
    w_mem_wb_nxt.regf_we        = ex_mem.valid & ex_mem.regf_we & !w_suppressed;
    w_mem_wb_nxt.regfilemux_sel = ex_mem.regfilemux_sel;
    w_mem_wb_nxt.dmem_addr      = w_mem_op ? ex_mem.alu_out : 32'b0;
    w_mem_wb_nxt.dmem_rmask     = dmem_rmask;
    w_mem_wb_nxt.dmem_wmask     = dmem_wmask;
    w_mem_wb_nxt.dmem_wdata     = dmem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_mem_wb <= '0;
    else if (!freeze_stall) r_mem_wb <= w_mem_wb_nxt;
  end

  assign mem_wb = r_mem_wb;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= r_misalign | (w_suppressed & !freeze_stall);
  end
  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (default and MEM_MISALIGN_TRAP_EN builds).
module tb_mem_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dmem_resp = 1'b0;
  ex_mem_stage_reg_t ex_mem;
  mem_wb_stage_reg_t mem_wb;
  logic [31:0]       dmem_addr, dmem_wdata, mem_fwd_v;
  logic [3:0]        dmem_rmask, dmem_wmask;
  logic              freeze_stall, misalign_err;
  int                n_chk = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_mem       (ex_mem),
    .mem_wb       (mem_wb),
    .dmem_addr    (dmem_addr),
    .dmem_rmask   (dmem_rmask),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_resp    (dmem_resp),
    .freeze_stall (freeze_stall),
    .mem_fwd_v    (mem_fwd_v),
    .misalign_err (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_stage_reg_t mk(input rv32i_opcode_t op, input logic [2:0] f3,
                                           input logic [31:0] alu, input logic [31:0] rs2,
                                           input regfilemux_sel_t sel, input logic we);
    ex_mem_stage_reg_t e;
    e = '0;
    e.valid = 1'b1;
    e.pc = 32'h100;
    e.inst = {25'b0, op};
    e.opcode = op;
    e.funct3 = f3;
    e.rd = 5'd1;
    e.alu_out = alu;
    e.rs2_v = rs2;
    e.regfilemux_sel = sel;
    e.regf_we = we;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ex_mem_stage_reg_t e;
    ex_mem = '0;
    tick();
    #1;
    chk("rst_stall", 32'(freeze_stall), 0);
    chk("rst_wb_valid", 32'(mem_wb.valid), 0);
    chk("rst_masks", {24'b0, dmem_rmask, dmem_wmask}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_err", 32'(misalign_err), 0);
    rst_n = 1'b1;

    // 1: sw, response arrives on the third cycle after issue
    tick(); ex_mem = mk(op_store, f3_sw, 32'h1000_0004, 32'hDEADBEEF, rf_alu_out, 1'b0); #1;
    chk("sw_addr", dmem_addr, 32'h1000_0004);
    chk("sw_wmask", 32'(dmem_wmask), 32'hF);
    chk("sw_rmask", 32'(dmem_rmask), 0);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall0", 32'(freeze_stall), 0);
    tick(); ex_mem = '0; #1;
    chk("sw_stall1", 32'(freeze_stall), 1);
    chk("sw_wmask_pulse", 32'(dmem_wmask), 0);
    chk("sw_wb_valid", 32'(mem_wb.valid), 1);
    chk("sw_wb_wmask", 32'(mem_wb.dmem_wmask), 32'hF);
    chk("sw_wb_addr", mem_wb.dmem_addr, 32'h1000_0004);
    tick(); #1;
    chk("sw_stall2", 32'(freeze_stall), 1);
    chk("sw_wb_hold", 32'(mem_wb.valid), 1);
    tick(); dmem_resp = 1'b1; #1;
    chk("sw_resp_stall", 32'(freeze_stall), 0);
    tick(); dmem_resp = 1'b0; #1;
    chk("sw_idle_stall", 32'(freeze_stall), 0);
    chk("sw_wb_bubble", 32'(mem_wb.valid), 0);

    // 2: sb to byte 3, then lh to upper half
    tick(); ex_mem = mk(op_store, f3_sb, 32'h2000_0003, 32'h0000_00AB, rf_alu_out, 1'b0); #1;
    chk("sb_wmask", 32'(dmem_wmask), 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_addr", dmem_addr, 32'h2000_0000);
    tick(); ex_mem = '0; dmem_resp = 1'b1; #1;
    chk("sb_resp_stall", 32'(freeze_stall), 0);
    tick(); dmem_resp = 1'b0; ex_mem = mk(op_load, f3_lh, 32'h2000_0002, 0, rf_lh, 1'b1); #1;
    chk("lh_rmask", 32'(dmem_rmask), 32'hC);
    chk("lh_wmask", 32'(dmem_wmask), 0);
    chk("lh_fwd", mem_fwd_v, 0);
    tick(); ex_mem = '0; dmem_resp = 1'b1; #1;
    chk("lh_wb_rmask", 32'(mem_wb.dmem_rmask), 32'hC);
    chk("lh_wb_addr", mem_wb.dmem_addr, 32'h2000_0002);
    tick(); dmem_resp = 1'b0;

    // 3: back-to-back lw, second issues in the first one's response cycle
    tick(); ex_mem = mk(op_load, f3_lw, 32'h3000_0000, 0, rf_lw, 1'b1); #1;
    chk("lw1_rmask", 32'(dmem_rmask), 32'hF);
    tick(); ex_mem = mk(op_load, f3_lw, 32'h3000_0008, 0, rf_lw, 1'b1); dmem_resp = 1'b1; #1;
    chk("b2b_stall", 32'(freeze_stall), 0);
    chk("b2b_rmask", 32'(dmem_rmask), 32'hF);
    chk("b2b_addr", dmem_addr, 32'h3000_0008);
    chk("b2b_wb1", mem_wb.alu_out, 32'h3000_0000);
    tick(); ex_mem = '0; dmem_resp = 1'b0; #1;
    chk("b2b_wait", 32'(freeze_stall), 1);
    chk("b2b_wb2", mem_wb.alu_out, 32'h3000_0008);
    tick(); dmem_resp = 1'b1; #1;
    chk("b2b_resp2", 32'(freeze_stall), 0);
    tick(); dmem_resp = 1'b0; #1;
    chk("b2b_idle", 32'(freeze_stall), 0);
    chk("b2b_wb_bubble", 32'(mem_wb.valid), 0);

    // 4: ALU ops and bubbles flow through every cycle
    tick(); ex_mem = mk(op_reg, 3'b000, 32'h55, 0, rf_alu_out, 1'b1); #1;
    chk("alu_fwd", mem_fwd_v, 32'h55);
    chk("alu_masks", {24'b0, dmem_rmask, dmem_wmask}, 0);
    chk("alu_stall", 32'(freeze_stall), 0);
    tick(); ex_mem = '0; #1;
    chk("alu_wb_valid", 32'(mem_wb.valid), 1);
    chk("alu_wb_alu", mem_wb.alu_out, 32'h55);
    chk("bub_fwd", mem_fwd_v, 0);
    tick(); e = mk(op_lui, 3'b000, 0, 0, rf_u_imm, 1'b1); e.u_imm = 32'h1234_5000; ex_mem = e; #1;
    chk("lui_fwd", mem_fwd_v, 32'h1234_5000);
    chk("bub_wb_valid", 32'(mem_wb.valid), 0);
    tick(); ex_mem = mk(op_jal, 3'b000, 0, 0, rf_pc_plus4, 1'b1); #1;
    chk("jal_fwd", mem_fwd_v, 32'h104);
    chk("lui_wb_uimm", mem_wb.u_imm, 32'h1234_5000);
    tick(); e = mk(op_br, 3'b000, 0, 0, rf_br_en, 1'b1); e.br_en = 1'b1; ex_mem = e; #1;
    chk("br_fwd", mem_fwd_v, 32'h1);
    chk("jal_wb_sel", 32'(mem_wb.regfilemux_sel), 32'(rf_pc_plus4));
    tick(); ex_mem = '0; #1;
    chk("br_wb_bren", 32'(mem_wb.br_en), 1);
    chk("alu_no_stall", 32'(freeze_stall), 0);

    // 5: reset while waiting drops the request; the late response is ignored
    tick(); ex_mem = mk(op_store, f3_sw, 32'h5000_0000, 32'h1, rf_alu_out, 1'b0); #1;
    tick(); ex_mem = '0; #1;
    chk("rstw_pre_stall", 32'(freeze_stall), 1);
    rst_n = 1'b0; #1;
    chk("rstw_stall", 32'(freeze_stall), 0);
    chk("rstw_wb_valid", 32'(mem_wb.valid), 0);
    tick(); rst_n = 1'b1; dmem_resp = 1'b1; #1;
    chk("rstw_resp_stall", 32'(freeze_stall), 0);
    chk("rstw_resp_masks", {24'b0, dmem_rmask, dmem_wmask}, 0);
    tick(); dmem_resp = 1'b0; ex_mem = mk(op_load, f3_lw, 32'h5000_0004, 0, rf_lw, 1'b1); #1;
    chk("rstw_post_rmask", 32'(dmem_rmask), 32'hF);
    tick(); ex_mem = '0; #1;
    chk("rstw_post_stall", 32'(freeze_stall), 1);
    tick(); dmem_resp = 1'b1; #1;
    tick(); dmem_resp = 1'b0;

    // 6: misaligned word load
    tick(); ex_mem = mk(op_load, f3_lw, 32'h6000_0001, 0, rf_lw, 1'b1); #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_masks", {24'b0, dmem_rmask, dmem_wmask}, 0);
    chk("mis_addr", dmem_addr, 0);
    chk("mis_stall0", 32'(freeze_stall), 0);
    tick(); ex_mem = '0; #1;
    chk("mis_err", 32'(misalign_err), 1);
    chk("mis_wb_we", 32'(mem_wb.regf_we), 0);
    chk("mis_wb_valid", 32'(mem_wb.valid), 1);
    chk("mis_wb_rmask", 32'(mem_wb.dmem_rmask), 0);
    chk("mis_stall1", 32'(freeze_stall), 0);
    tick(); tick(); #1;
    chk("mis_err_sticky", 32'(misalign_err), 1);
`else
    chk("mis_rmask", 32'(dmem_rmask), 32'hF);
    chk("mis_addr", dmem_addr, 32'h6000_0000);
    tick(); ex_mem = mk(op_load, f3_lh, 32'h6000_0003, 0, rf_lh, 1'b1); #1;
    chk("mis_wait", 32'(freeze_stall), 1);
    chk("mis_err", 32'(misalign_err), 0);
    chk("mis_wb_we", 32'(mem_wb.regf_we), 1);
    tick(); dmem_resp = 1'b1; #1;
    chk("mish_rmask", 32'(dmem_rmask), 32'hC);
    tick(); ex_mem = '0; dmem_resp = 1'b0; #1;
    chk("mish_wait", 32'(freeze_stall), 1);
    tick(); dmem_resp = 1'b1; #1;
    chk("mish_resp", 32'(freeze_stall), 0);
    tick(); dmem_resp = 1'b0; #1;
    chk("mis_err_tied", 32'(misalign_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
